// File: rtl/id_hazard_control.sv
// id_hazard_control: decode-stage load-use stall, MEM-redirect flush and HLT drain controller.
// Optional perf counters (stall_cnt/flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module id_hazard_control #(
    parameter int REG_W        = 4,
    parameter int DRAIN_CYCLES = 3
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W      = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_hlt,
    input  logic             ex_MemRead,
    input  logic             ex_RegWrite,
    input  logic [REG_W-1:0] ex_Rd,
    input  logic             mem_redirect,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_clear,
    output logic             idex_write_en,
    output logic             idex_clear,
    output logic             exmem_clear,
    output logic             halted
`ifdef HAZARD_PERF_CNT_EN
    , output logic [CNT_W-1:0] stall_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;
    state_t     state_q, state_d;
    logic [1:0] drn_cnt_q, drn_cnt_d;
    logic       in_run, in_drain, in_halt, load_use, redir, stall, take_hlt, advance;
    assign in_run   = state_q == RUN;
    assign in_drain = state_q == DRAIN;
    assign in_halt  = state_q == HALTED;
    assign load_use = ex_MemRead && ex_RegWrite && ex_Rd != '0 &&
                      ((id_uses_rs && id_rs == ex_Rd) || (id_uses_rt && id_rt == ex_Rd));
    assign redir    = mem_redirect && !in_halt;
    assign stall    = in_run && !mem_redirect && load_use;
    assign take_hlt = in_run && !mem_redirect && !load_use && id_is_hlt;
    assign advance  = redir || (in_run && !load_use && !id_is_hlt);
    // Outputs are forced to the safe freeze/flush pattern for as long as rst_n is low.
    assign pc_write      = rst_n && advance;
    assign ifid_write    = rst_n && advance;
    assign ifid_clear    = !rst_n || redir;
    assign idex_write_en = rst_n && !in_halt;
    assign idex_clear    = !rst_n || redir || stall || in_drain;
    assign exmem_clear   = !rst_n || redir;
    assign halted        = rst_n && in_halt;
    always_comb begin
        state_d   = state_q;
        drn_cnt_d = drn_cnt_q;
        if (take_hlt) begin
            state_d   = DRAIN;
            drn_cnt_d = 2'(DRAIN_CYCLES - 1);
        end else if (in_drain) begin
            state_d   = redir ? RUN : (drn_cnt_q == 2'd0 ? HALTED : DRAIN);
            drn_cnt_d = (redir || drn_cnt_q == 2'd0) ? 2'd0 : drn_cnt_q - 2'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            drn_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            drn_cnt_q <= drn_cnt_d;
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
            flush_cnt_q <= (redir && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
        end
    end
`endif
endmodule

// File: tb/tb_id_hazard_control.sv
// tb_id_hazard_control: directed checks of stall, flush, HLT drain/halt and async reset behaviour.
module tb_id_hazard_control;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] id_rs, id_rt, ex_Rd;
    logic       id_uses_rs, id_uses_rt, id_is_hlt, ex_MemRead, ex_RegWrite, mem_redirect;
    logic       pc_write, ifid_write, ifid_clear, idex_write_en, idex_clear, exmem_clear, halted;
    logic [6:0] outs;
    int         errs = 0, checks = 0;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif
    // Output vector order: {pc_write, ifid_write, ifid_clear, idex_write_en, idex_clear, exmem_clear, halted}
    localparam logic [6:0] O_RST   = 7'b0010110;
    localparam logic [6:0] O_RUN   = 7'b1101000;
    localparam logic [6:0] O_STALL = 7'b0001100;
    localparam logic [6:0] O_REDIR = 7'b1111110;
    localparam logic [6:0] O_HLT   = 7'b0001000;
    localparam logic [6:0] O_DRAIN = 7'b0001100;
    localparam logic [6:0] O_HALT  = 7'b0000001;
    id_hazard_control dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_hlt(id_is_hlt),
        .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite), .ex_Rd(ex_Rd),
        .mem_redirect(mem_redirect), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_clear(ifid_clear), .idex_write_en(idex_write_en), .idex_clear(idex_clear),
        .exmem_clear(exmem_clear), .halted(halted)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );
    always #5 clk = ~clk;
    assign outs = {pc_write, ifid_write, ifid_clear, idex_write_en, idex_clear, exmem_clear, halted};
    task automatic drv(input logic mr, input logic rw, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic urs, input logic urt, input logic hlt,
                       input logic redir);
        ex_MemRead = mr; ex_RegWrite = rw; ex_Rd = rd; id_rs = rs; id_rt = rt;
        id_uses_rs = urs; id_uses_rt = urt; id_is_hlt = hlt; mem_redirect = redir;
    endtask
    task automatic chk(input string tag, input logic [6:0] exp);
        checks++;
        assert (outs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%b expected=%b", tag, outs, exp);
        end
    endtask
    task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic step(input string tag, input logic [6:0] exp);
        @(negedge clk);
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask
    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("reset_outputs", O_RST);
        release_rst();
        step("idle_run", O_RUN);
        drv(1, 1, 4, 4, 0, 1, 0, 0, 0);
        step("load_use_rs", O_STALL);
        drv(0, 1, 4, 4, 0, 1, 0, 0, 0);
        step("after_stall", O_RUN);
        drv(1, 1, 7, 2, 7, 1, 1, 0, 0);
        step("load_use_rt", O_STALL);
        drv(1, 1, 4, 4, 0, 0, 0, 0, 0);
        step("match_unused_rs", O_RUN);
        drv(1, 0, 4, 4, 0, 1, 0, 0, 0);
        step("no_regwrite", O_RUN);
        drv(1, 1, 0, 0, 0, 1, 1, 0, 0);
        step("r0_no_hazard", O_RUN);
        drv(1, 1, 4, 4, 0, 1, 0, 0, 1);
        step("load_use_plus_redirect", O_REDIR);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        chkv("stall_cnt_after_redirect", stall_cnt, 16'd2);
        chkv("flush_cnt_after_redirect", flush_cnt, 16'd1);
`endif
        drv(1, 1, 5, 5, 0, 1, 0, 1, 0);
        step("hlt_with_load_use", O_STALL);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("hlt_enters", O_HLT);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("drain_1", O_DRAIN);
        step("drain_2", O_DRAIN);
        step("drain_3", O_DRAIN);
        step("halted", O_HALT);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("halted_redirect_ignored", O_HALT);
        drv(1, 1, 4, 4, 0, 1, 0, 0, 0);
        step("halted_sticky", O_HALT);
`ifdef HAZARD_PERF_CNT_EN
        chkv("stall_cnt_halted", stall_cnt, 16'd3);
        chkv("flush_cnt_halted", flush_cnt, 16'd1);
`endif
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1 chk("reset_exits_halt", O_RST);
        release_rst();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("hlt2_enters", O_HLT);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("drain2_1", O_DRAIN);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("drain_redirect", O_REDIR);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("cancelled_run_1", O_RUN);
        step("cancelled_run_2", O_RUN);
        step("cancelled_run_3", O_RUN);
`ifdef HAZARD_PERF_CNT_EN
        chkv("flush_cnt_drain_redirect", flush_cnt, 16'd1);
        chkv("stall_cnt_after_reset", stall_cnt, 16'd0);
`endif
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("hlt3_enters", O_HLT);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("drain3_1", O_DRAIN);
        rst_n = 1'b0;
        #1 chk("reset_mid_drain", O_RST);
`ifdef HAZARD_PERF_CNT_EN
        chkv("flush_cnt_reset", flush_cnt, 16'd0);
`endif
        release_rst();
        step("post_reset_run_1", O_RUN);
        step("post_reset_run_2", O_RUN);
        step("post_reset_run_3", O_RUN);
        drv(1, 1, 9, 9, 0, 1, 0, 0, 0);
        step("post_reset_stall", O_STALL);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
